wb_dual_port_ram: RTL
=====================

# wb_dual_port_ram

Parametrised true dual-port byte-enabled RAM with two pipelined Wishbone slave ports, the next generation of the lab's shared-memory block. It adds registered read data, ack generation, a stall (wait-request) output and deterministic arbitration of same-address write collisions. It sits between two bus masters (e.g. CPU and DMA/accelerator) that share a scratch buffer.

## Interface
- ADDR_WIDTH, 5, word address width; depth = 2**ADDR_WIDTH words
- DATA_WIDTH, 32, word width; must be a multiple of 8
- BE_WIDTH, DATA_WIDTH/8, byte-select width (derived, not overridden)
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- portN_adr_i  in  ADDR_WIDTH  word address (N = 1, 2; all port signals below exist for both ports)
- portN_data_i  in  DATA_WIDTH  write data
- portN_data_o  out  DATA_WIDTH  registered read data, valid with ack
- portN_we_i  in  1  1 = write, 0 = read
- portN_sel_i  in  BE_WIDTH  byte lane enables
- portN_stb_i  in  1  strobe
- portN_cyc_i  in  1  cycle valid
- portN_ack_o  out  1  acknowledge, one per accepted request
- portN_stall_o  out  1  request not accepted this cycle
- portN_tagn_i  in  1  cycle tag in
- portN_tagn_o  out  1  tag returned alongside ack

## Operation
- Request accepted on a port when cyc & stb & !stall at a rising edge.
- Accepted write: for each lane b with sel[b]=1, mem[adr][8b+7:8b] <= data_i; unselected lanes unchanged.
- Accepted read: data_o <= mem[adr] with unselected lanes forced to 0.
- Accepted write: data_o <= 0.
- Read/write of the same address by opposite ports in the same cycle: read returns old contents (read-before-write).
- Collision: both ports present a write to the same address in the same cycle. Exactly one port is accepted; the other sees stall=1 that cycle and retries next cycle. Lane overlap is not considered.
- Priority register `prio` (0 = port1 wins, 1 = port2 wins). On reset, prio = 0.
- After any collision, prio switches to the loser. Each master is therefore stalled at most one cycle in a row.
- Without a collision, stall = 0 and both ports are accepted.
- tagn_o <= tagn_i of the accepted request, presented with the ack.
- cyc deasserted while an ack is pending: the ack is still issued next cycle, and the master ignores it.
- Out-of-range address is impossible; depth is exactly 2**ADDR_WIDTH.
- Memory contents are not reset.

## Timing
- Reset values: ack_o = 0, stall_o = 0, data_o = 0, tagn_o = 0, prio = 0.
- Reset asserted mid-operation: all pending acks are dropped immediately.
- Latency: ack_o and data_o one cycle after acceptance.
- Throughput: one request per cycle per port, back-to-back, with no idle cycle required.
- stall_o is combinational from both ports' cyc/stb/we/adr and prio. ack_o, data_o and tagn_o are registered.
- Write data is visible to either port's read accepted one cycle later or after.

## Structure
- Package wb_dp_ram_pkg holds:
  - the collision-priority enum `prio_e` (PRIO_P1, PRIO_P2);
  - the lane-mask function expanding sel to a DATA_WIDTH bit mask;
  - the width-check localparams.
- Sub-module wb_ram_port, instantiated twice, contains:
  - request accept logic;
  - the ack/tag/data_o output registers;
  - read-lane masking.
- The top level contains the memory array, the collision detector and prio.

## Test plan
- Reset: drive reset=0 mid-burst, with ack pending on both ports. All outputs read 0 while reset is low, and prio=0 after release.
- Byte-enable write and read:
  - port1 writes 0xAABBCCDD to addr 3 with sel=0xF, then writes 0x11223344 to addr 3 with sel=0x5;
  - port2 then reads addr 3 with sel=0xF -> 0xAA22CC44, ack one cycle later;
  - port2 reads addr 3 with sel=0x3 -> 0x0000CC44.
- Back-to-back pipeline: port1 issues reads of addr 0..7 on consecutive cycles -> 8 acks on consecutive cycles, data in order, stall never asserted.
- Collision fairness:
  - both ports write addr 9 every cycle for 4 cycles (p1 data 0x1, p2 data 0x2);
  - acceptance alternates p1, p2, p1, p2 and each stall is one cycle;
  - final mem[9] is written by the last accepted write.
- Read-before-write: port1 writes 0x55 to addr 4 while port2 reads addr 4 in the same cycle -> port2 gets the old value; a port2 read of addr 4 on the next cycle -> 0x55.
- Tag and parameters: repeat the byte-enable test with DATA_WIDTH=64, ADDR_WIDTH=8 on address 255. Check that tagn_o matches tagn_i of each accepted request.

Source files
------------

// File: rtl/wb_dp_ram_pkg.sv
// rtl/wb_dp_ram_pkg.sv - shared types and helpers for the Wishbone dual-port RAM
//
// Purpose: collision-priority enum, byte-lane width constants and the
// byte-select to bit-mask expansion used by both RAM ports.
// Ports: none (package).
package wb_dp_ram_pkg;

  localparam int BYTE_W         = 8;
  localparam int MAX_DATA_WIDTH = 256;
  localparam int MAX_BE_WIDTH   = MAX_DATA_WIDTH / BYTE_W;

  // Which port wins the next same-address write collision.
  typedef enum logic {
    PRIO_P1 = 1'b0,
    PRIO_P2 = 1'b1
  } prio_e;

  // Expands one select bit per byte lane into a full-width bit mask.
  // Callers zero-extend sel and cast the result down to their own width.
  function automatic logic [MAX_DATA_WIDTH-1:0] lane_mask(
    input logic [MAX_BE_WIDTH-1:0] sel
  );
    logic [MAX_DATA_WIDTH-1:0] m;
    for (int b = 0; b < MAX_BE_WIDTH; b++) begin
      m[b*BYTE_W +: BYTE_W] = {BYTE_W{sel[b]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/wb_ram_port.sv
// rtl/wb_ram_port.sv - one pipelined Wishbone slave port of the dual-port RAM
//
// Purpose: accepts a request when cyc & stb & !stall, registers ack, tag and
// read data one cycle later, masks unselected read lanes to zero and hands
// the write enable and lane mask to the memory array in the top level.
// Ports:
//   clk, reset       clock, asynchronous active-low reset
//   cyc_i, stb_i     Wishbone cycle / strobe
//   we_i, sel_i      write enable, byte lane selects
//   tagn_i           request tag, returned with the ack
//   stall_i          collision stall from the top-level arbiter
//   rd_word_i        current memory word at this port's address
//   wr_en_o          accepted write this cycle
//   lane_mask_o      sel expanded to a bit mask
//   data_o, ack_o, tagn_o  registered response
module wb_ram_port
  import wb_dp_ram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cyc_i,
  input  logic                  stb_i,
  input  logic                  we_i,
  input  logic [BE_WIDTH-1:0]   sel_i,
  input  logic                  tagn_i,
  input  logic                  stall_i,
  input  logic [DATA_WIDTH-1:0] rd_word_i,
  output logic                  wr_en_o,
  output logic [DATA_WIDTH-1:0] lane_mask_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  ack_o,
  output logic                  tagn_o
);

  logic                  accept;
  logic                  ack_q, ack_d;
  logic                  tagn_q, tagn_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  // Nothing is accepted while reset is low, so the memory is untouched then.
  assign accept      = reset & cyc_i & stb_i & ~stall_i;
  assign wr_en_o     = accept & we_i;
  assign lane_mask_o = DATA_WIDTH'(lane_mask(MAX_BE_WIDTH'(sel_i)));

  always_comb begin
    ack_d  = accept;
    tagn_d = tagn_q;
    data_d = data_q;
    if (accept) begin
      tagn_d = tagn_i;
      // rd_word_i is the pre-write contents, giving read-before-write.
      data_d = we_i ? '0 : (rd_word_i & lane_mask_o);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ack_q  <= 1'b0;
      tagn_q <= 1'b0;
      data_q <= '0;
    end else begin
      ack_q  <= ack_d;
      tagn_q <= tagn_d;
      data_q <= data_d;
    end
  end

  assign ack_o  = ack_q;
  assign tagn_o = tagn_q;
  assign data_o = data_q;

endmodule

// File: rtl/wb_dual_port_ram.sv
// rtl/wb_dual_port_ram.sv - byte-enabled true dual-port RAM with two Wishbone ports
//
// Purpose: shared scratch memory between two bus masters. Holds the memory
// array, detects same-address write collisions and alternates the winner.
// Ports (N = 1, 2):
//   clk, reset          clock, asynchronous active-low reset
//   portN_adr_i         word address
//   portN_data_i/_o     write data / registered read data (valid with ack)
//   portN_we_i          1 = write, 0 = read
//   portN_sel_i         byte lane enables
//   portN_stb_i/_cyc_i  Wishbone strobe / cycle
//   portN_ack_o         one ack per accepted request, one cycle later
//   portN_stall_o       request not accepted this cycle (collision loser)
//   portN_tagn_i/_o     tag in / tag returned with the ack
module wb_dual_port_ram
  import wb_dp_ram_pkg::*;
#(
  parameter  int ADDR_WIDTH = 5,
  parameter  int DATA_WIDTH = 32,
  localparam int BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] port1_adr_i,
  input  logic [DATA_WIDTH-1:0] port1_data_i,
  output logic [DATA_WIDTH-1:0] port1_data_o,
  input  logic                  port1_we_i,
  input  logic [BE_WIDTH-1:0]   port1_sel_i,
  input  logic                  port1_stb_i,
  input  logic                  port1_cyc_i,
  output logic                  port1_ack_o,
  output logic                  port1_stall_o,
  input  logic                  port1_tagn_i,
  output logic                  port1_tagn_o,
  input  logic [ADDR_WIDTH-1:0] port2_adr_i,
  input  logic [DATA_WIDTH-1:0] port2_data_i,
  output logic [DATA_WIDTH-1:0] port2_data_o,
  input  logic                  port2_we_i,
  input  logic [BE_WIDTH-1:0]   port2_sel_i,
  input  logic                  port2_stb_i,
  input  logic                  port2_cyc_i,
  output logic                  port2_ack_o,
  output logic                  port2_stall_o,
  input  logic                  port2_tagn_i,
  output logic                  port2_tagn_o
);

  localparam int DEPTH    = 2 ** ADDR_WIDTH;
  localparam bit WIDTH_OK = (DATA_WIDTH > 0) && (DATA_WIDTH % BYTE_W == 0) &&
                            (DATA_WIDTH <= MAX_DATA_WIDTH);

  if (!WIDTH_OK) begin : g_width_check
    $error("wb_dual_port_ram: DATA_WIDTH must be a multiple of 8, at most 256");
  end

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  prio_e                 prio_q, prio_d;
  logic                  wr1_req, wr2_req, collide;
  logic                  wr1_en, wr2_en;
  logic [DATA_WIDTH-1:0] mask1, mask2;
  logic [DATA_WIDTH-1:0] rd1_word, rd2_word;

  // Only write/write to the same word collides; byte lanes are not compared.
  assign wr1_req = port1_cyc_i & port1_stb_i & port1_we_i;
  assign wr2_req = port2_cyc_i & port2_stb_i & port2_we_i;
  assign collide = wr1_req & wr2_req & (port1_adr_i == port2_adr_i);

  // Stall is gated by reset so every output reads 0 while reset is low.
  assign port1_stall_o = reset & collide & (prio_q == PRIO_P2);
  assign port2_stall_o = reset & collide & (prio_q == PRIO_P1);

  // The loser of a collision wins the next one.
  always_comb begin
    prio_d = prio_q;
    if (collide) begin
      prio_d = (prio_q == PRIO_P1) ? PRIO_P2 : PRIO_P1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prio_q <= PRIO_P1;
    end else begin
      prio_q <= prio_d;
    end
  end

  assign rd1_word = mem_q[port1_adr_i];
  assign rd2_word = mem_q[port2_adr_i];

  // Memory contents are deliberately not reset. Arbitration guarantees the
  // two writes never target the same word in one cycle.
  always_ff @(posedge clk) begin
    if (wr1_en) begin
      mem_q[port1_adr_i] <= (mem_q[port1_adr_i] & ~mask1) | (port1_data_i & mask1);
    end
    if (wr2_en) begin
      mem_q[port2_adr_i] <= (mem_q[port2_adr_i] & ~mask2) | (port2_data_i & mask2);
    end
  end

  wb_ram_port #(.DATA_WIDTH(DATA_WIDTH), .BE_WIDTH(BE_WIDTH)) u_port1 (
    .clk         (clk),
    .reset       (reset),
    .cyc_i       (port1_cyc_i),
    .stb_i       (port1_stb_i),
    .we_i        (port1_we_i),
    .sel_i       (port1_sel_i),
    .tagn_i      (port1_tagn_i),
    .stall_i     (port1_stall_o),
    .rd_word_i   (rd1_word),
    .wr_en_o     (wr1_en),
    .lane_mask_o (mask1),
    .data_o      (port1_data_o),
    .ack_o       (port1_ack_o),
    .tagn_o      (port1_tagn_o)
  );

  wb_ram_port #(.DATA_WIDTH(DATA_WIDTH), .BE_WIDTH(BE_WIDTH)) u_port2 (
    .clk         (clk),
    .reset       (reset),
    .cyc_i       (port2_cyc_i),
    .stb_i       (port2_stb_i),
    .we_i        (port2_we_i),
    .sel_i       (port2_sel_i),
    .tagn_i      (port2_tagn_i),
    .stall_i     (port2_stall_o),
    .rd_word_i   (rd2_word),
    .wr_en_o     (wr2_en),
    .lane_mask_o (mask2),
    .data_o      (port2_data_o),
    .ack_o       (port2_ack_o),
    .tagn_o      (port2_tagn_o)
  );

endmodule
